// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared encodings for the data-memory responder: access size
//                codes, responder FSM state codes and the legal wait-state
//                range.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Access size as presented on req_size (00 word, 01 half, 10 byte).
    localparam logic [1:0] SZ_WORD    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_BYTE    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Responder FSM states.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Largest wait-state count the 4-bit wait counter can represent.
    localparam int WAIT_STATES_MAX = 15;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational big-endian byte-lane steering for a 32-bit
//                word memory. Produces the store bit-mask and replicated
//                store data, extracts and sign/zero-extends load data, and
//                flags misaligned or illegal-size accesses.
//  Ports       : addr_lo  - byte address bits [30:31] (bit 0 = MSB)
//                size     - access size code (dmem_pkg SZ_*)
//                sign     - sign-extend sub-word loads
//                wdata    - right-justified store data
//                rword    - word read from the array
//                wmask    - per-bit write enable for the array word
//                wword    - store data placed on the addressed lane(s)
//                rdata    - right-justified, extended load result
//                misalign - access is misaligned or of illegal size
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import dmem_pkg::*;
(
    input  logic [0:1]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [0:31] wdata,
    input  logic [0:31] rword,
    output logic [0:31] wmask,
    output logic [0:31] wword,
    output logic [0:31] rdata,
    output logic        misalign
);

    logic [0:7]  w_byte;
    logic [0:15] w_half;

    always_comb begin
        // Lane 00 is the most significant byte of the word.
        w_byte = 8'h00;
        case (addr_lo)
            2'b00:   w_byte = rword[0:7];
            2'b01:   w_byte = rword[8:15];
            2'b10:   w_byte = rword[16:23];
            default: w_byte = rword[24:31];
        endcase
        w_half = addr_lo[0] ? rword[16:31] : rword[0:15];

        misalign = 1'b0;
        wmask    = '0;
        wword    = '0;
        rdata    = '0;

        case (size)
            SZ_WORD: begin
                misalign = (addr_lo != 2'b00);
                wmask    = '1;
                wword    = wdata;
                rdata    = rword;
            end
            SZ_HALF: begin
                misalign = addr_lo[1];
                wmask    = addr_lo[0] ? 32'h0000_FFFF : 32'hFFFF_0000;
                wword    = {2{wdata[16:31]}};
                rdata    = {{16{sign & w_half[0]}}, w_half};
            end
            SZ_BYTE: begin
                case (addr_lo)
                    2'b00:   wmask = 32'hFF00_0000;
                    2'b01:   wmask = 32'h00FF_0000;
                    2'b10:   wmask = 32'h0000_FF00;
                    default: wmask = 32'h0000_00FF;
                endcase
                wword = {4{wdata[24:31]}};
                rdata = {{24{sign & w_byte[0]}}, w_byte};
            end
            default: begin
                misalign = 1'b1;
            end
        endcase

        // A faulting access neither writes nor returns data.
        if (misalign) begin
            wmask = '0;
            rdata = '0;
        end
    end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Memory-stage load/store responder with a programmable number
//                of wait states in front of a word-organised big-endian SRAM.
//                Freezes the pipeline for the whole access and returns a
//                one-cycle response with aligned, extended load data.
//  Ports       : clk, reset (async, active-high)
//                req_valid/req_we/req_addr/req_wdata/req_size/req_sign
//                         - request, held stable by the requester while stalled
//                stall    - pipeline freeze
//                rdata    - load result (0 for stores and faults)
//                rvalid   - one-cycle response strobe
//                err      - misaligned / illegal-size flag, qualified by rvalid
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [0:31] req_addr,
    input  logic [0:31] req_wdata,
    input  logic [0:1]  req_size,
    input  logic        req_sign,
    output logic        stall,
    output logic [0:31] rdata,
    output logic        rvalid,
    output logic        err
);

    localparam int         DEPTH       = 2 ** (ADDR_BITS - 2);
    localparam logic [3:0] c_WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    if (WAIT_STATES < 0 || WAIT_STATES > WAIT_STATES_MAX) begin : g_wait_states_range
        $error("data_mem_responder: WAIT_STATES out of range 0..15");
    end

    logic [1:0]             r_state;
    logic [3:0]             r_cnt;
    logic                   r_we;
    logic [32-ADDR_BITS:31] r_addr;
    logic [0:31]            r_wdata;
    logic [1:0]             r_size;
    logic                   r_sign;
    logic [0:31]            r_rdata;
    logic                   r_rvalid;
    logic                   r_err;
    logic [0:31]            r_mem [0:DEPTH-1];

    logic [0:ADDR_BITS-3]   w_idx;
    logic [0:31]            w_rword;
    logic [0:31]            w_wmask;
    logic [0:31]            w_wword;
    logic [0:31]            w_load;
    logic                   w_misalign;
    logic                   w_unused_addr;

    // Address bits above the array size are ignored, so the array wraps.
    assign w_unused_addr = ^req_addr[0:31-ADDR_BITS];
    assign w_idx         = r_addr[32-ADDR_BITS:29];
    assign w_rword       = r_mem[w_idx];

    mem_lane_align u_align (
        .addr_lo  (r_addr[30:31]),
        .size     (r_size),
        .sign     (r_sign),
        .wdata    (r_wdata),
        .rword    (w_rword),
        .wmask    (w_wmask),
        .wword    (w_wword),
        .rdata    (w_load),
        .misalign (w_misalign)
    );

    // Stall is combinational in IDLE so the request's first cycle is frozen.
    assign stall  = ~reset & (((r_state == ST_IDLE) & req_valid) |
                              (r_state == ST_WAIT) | (r_state == ST_ACCESS));
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign err    = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_size   <= 2'b00;
            r_sign   <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr[32-ADDR_BITS:31];
                        r_wdata <= req_wdata;
                        r_size  <= req_size;
                        r_sign  <= req_sign;
                        if (WAIT_STATES == 0) begin
                            r_state <= ST_ACCESS;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    r_state  <= ST_RESP;
                    r_rvalid <= 1'b1;
                    r_err    <= w_misalign;
                    r_rdata  <= (r_we | w_misalign) ? '0 : w_load;
                end
                ST_RESP: begin
                    // The request still on the bus is the one just served.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if ((r_state == ST_ACCESS) && r_we && !w_misalign) begin
            r_mem[w_idx] <= (w_rword & ~w_wmask) | (w_wword & w_wmask);
        end
    end

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Scoreboard bench for data_mem_responder. Two instances are
//                exercised: index 0 with WAIT_STATES=2, index 1 with
//                WAIT_STATES=0. Expected responses come from a byte-array
//                reference memory and are checked by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int N = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid [N];
    logic        req_we    [N];
    logic [0:31] req_addr  [N];
    logic [0:31] req_wdata [N];
    logic [0:1]  req_size  [N];
    logic        req_sign  [N];
    logic        stall     [N];
    logic [0:31] rdata     [N];
    logic        rvalid    [N];
    logic        err       [N];

    data_mem_responder #(.ADDR_BITS(12), .WAIT_STATES(2)) u_dut_ws2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_size(req_size[0]), .req_sign(req_sign[0]),
        .stall(stall[0]), .rdata(rdata[0]), .rvalid(rvalid[0]), .err(err[0])
    );

    data_mem_responder #(.ADDR_BITS(12), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_size(req_size[1]), .req_sign(req_sign[1]),
        .stall(stall[1]), .rdata(rdata[1]), .rvalid(rvalid[1]), .err(err[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
    } req_t;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t       sb[$];
    req_t       pend[$];
    logic [7:0] mdl [N][4096];
    int         tests = 0;
    int         fails = 0;

    function automatic int ws_of(input int id);
        return (id == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference memory: a flat big-endian byte array, 4 KiB, address wraps.
    task automatic model(input int id, input req_t r, output logic [31:0] d, output logic e);
        int          a;
        logic [15:0] h;
        logic [7:0]  b;
        a = int'(r.addr[11:0]);
        d = 32'h0;
        e = 1'b0;
        if (r.size == 2'd3 || (r.size == 2'd1 && (a % 2) != 0) || (r.size == 2'd0 && (a % 4) != 0)) begin
            e = 1'b1;
        end else if (r.we) begin
            if (r.size == 2'd0) begin
                for (int i = 0; i < 4; i++) mdl[id][a+i] = r.wdata[31-8*i -: 8];
            end else if (r.size == 2'd1) begin
                mdl[id][a]   = r.wdata[15:8];
                mdl[id][a+1] = r.wdata[7:0];
            end else begin
                mdl[id][a] = r.wdata[7:0];
            end
        end else begin
            if (r.size == 2'd0) begin
                d = {mdl[id][a], mdl[id][a+1], mdl[id][a+2], mdl[id][a+3]};
            end else if (r.size == 2'd1) begin
                h = {mdl[id][a], mdl[id][a+1]};
                d = r.sign ? 32'($signed(h)) : 32'(h);
            end else begin
                b = mdl[id][a];
                d = r.sign ? 32'($signed(b)) : 32'(b);
            end
        end
    endtask

    task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic sign);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.size = size; r.sign = sign;
        pend.push_back(r);
    endtask

    task automatic drive(input int id, input req_t r);
        exp_t        x;
        logic [31:0] d;
        logic        e;
        req_valid[id] = 1'b1;
        req_we[id]    = r.we;
        req_addr[id]  = r.addr;
        req_wdata[id] = r.wdata;
        req_size[id]  = r.size;
        req_sign[id]  = r.sign;
        model(id, r, d, e);
        x.id = id; x.data = d; x.err = e;
        sb.push_back(x);
    endtask

    // Issues every pending request; with b2b set, req_valid stays high and the
    // next request is presented during the response cycle of the previous one.
    task automatic run(input int id, input bit b2b);
        int   k;
        int   sc;
        bit   got;
        bit   first;
        req_t r;
        first = 1'b1;
        while (pend.size() > 0) begin
            r = pend.pop_front();
            if (first || !b2b) begin
                @(negedge clk);
                drive(id, r);
            end else begin
                drive(id, r);
                @(negedge clk);
            end
            #1;
            k = 0; sc = 0; got = 1'b0;
            while (!got && k < 64) begin
                if (stall[id]) sc++;
                if (rvalid[id]) got = 1'b1;
                else begin
                    @(negedge clk); #1;
                    k++;
                end
            end
            if (!got) begin
                tests++;
                fails++;
                $display("FAIL rvalid_timeout dut%0d: no rvalid within 64 cycles", id);
            end else begin
                check("latency", k, ws_of(id) + 2);
                check("stall_cycles", sc, ws_of(id) + 2);
            end
            first = 1'b0;
            if (!b2b || pend.size() == 0) req_valid[id] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic push_random();
        logic [1:0]  sz;
        int          sel;
        logic [31:0] lo;
        logic [31:0] hi;
        sel = $urandom_range(0, 9);
        sz  = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
        lo  = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd0) lo = lo & ~32'd3;
            if (sz == 2'd1) lo = lo & ~32'd1;
        end
        hi = ($urandom_range(0, 1) != 0) ? ($urandom & 32'hFFFF_F000) : 32'h0;
        push_req(1'($urandom_range(0, 1)), hi | lo, $urandom, sz, 1'($urandom_range(0, 1)));
    endtask

    // Monitor: every response strobe must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int id = 0; id < N; id++) begin
            if (rvalid[id]) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rvalid dut%0d: rvalid with no request outstanding", id);
                end else begin
                    e = sb.pop_front();
                    check("resp_dut_id", id, e.id);
                    check("rdata", rdata[id], e.data);
                    check("err", {31'h0, err[id]}, {31'h0, e.err});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0;   req_size[i] = 2'b00; req_sign[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check("reset_stall",  {31'h0, stall[i]},  32'h0);
            check("reset_rvalid", {31'h0, rvalid[i]}, 32'h0);
            check("reset_rdata",  rdata[i],           32'h0);
            check("reset_err",    {31'h0, err[i]},    32'h0);
        end

        // Give every word the random tests touch a defined value.
        for (int w = 0; w < 16; w++) push_req(1'b1, 32'(w * 4), $urandom, 2'd0, 1'b0);
        run(0, 1'b1);

        // Word store/load round trip.
        push_req(1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 1'b0);
        push_req(1'b0, 32'h10, 32'h0,        2'd0, 1'b0);
        run(0, 1'b0);

        // Byte insert and sign/zero-extended byte loads.
        push_req(1'b1, 32'h20, 32'h11223344, 2'd0, 1'b0);
        push_req(1'b1, 32'h21, 32'h000000A5, 2'd2, 1'b0);
        push_req(1'b0, 32'h20, 32'h0,        2'd0, 1'b0);
        push_req(1'b0, 32'h21, 32'h0,        2'd2, 1'b1);
        push_req(1'b0, 32'h21, 32'h0,        2'd2, 1'b0);
        run(0, 1'b0);

        // Halfword loads, misaligned accesses and the illegal size.
        push_req(1'b1, 32'h20, 32'h1122F344, 2'd0, 1'b0);
        push_req(1'b0, 32'h22, 32'h0,        2'd1, 1'b1);
        push_req(1'b0, 32'h23, 32'h0,        2'd1, 1'b1);
        push_req(1'b0, 32'h20, 32'h0,        2'd0, 1'b0);
        push_req(1'b1, 32'h12, 32'h0BADF00D, 2'd0, 1'b0);
        push_req(1'b0, 32'h10, 32'h0,        2'd0, 1'b0);
        push_req(1'b0, 32'h10, 32'h0,        2'd3, 1'b0);
        push_req(1'b1, 32'h16, 32'h00001234, 2'd1, 1'b0);
        push_req(1'b0, 32'h14, 32'h0,        2'd0, 1'b0);
        run(0, 1'b0);

        // Address aliasing above ADDR_BITS.
        push_req(1'b1, 32'h1010, 32'h5A5A0F0F, 2'd0, 1'b0);
        push_req(1'b0, 32'h0010, 32'h0,        2'd0, 1'b0);
        run(0, 1'b0);

        // Reset while a store sits in WAIT: the store must be discarded.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h30;
        req_wdata[0] = 32'hCAFEF00D; req_size[0] = 2'd0; req_sign[0] = 1'b0;
        @(negedge clk);
        #1;
        check("stall_in_wait", {31'h0, stall[0]}, 32'h1);
        reset = 1'b1;
        req_valid[0] = 1'b0;
        #1;
        check("reset_mid_stall",  {31'h0, stall[0]},  32'h0);
        check("reset_mid_rvalid", {31'h0, rvalid[0]}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        push_req(1'b0, 32'h30, 32'h0, 2'd0, 1'b0);
        run(0, 1'b0);

        // Randomised mix, alternating isolated and back-to-back bursts.
        for (int c = 0; c < 10; c++) begin
            for (int j = 0; j < 6; j++) push_random();
            run(0, 1'($urandom_range(0, 1)));
        end

        // Eight requests with req_valid held continuously.
        for (int j = 0; j < 8; j++) push_random();
        run(0, 1'b1);

        // Zero-wait-state instance.
        push_req(1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 1'b0);
        push_req(1'b0, 32'h10, 32'h0,        2'd0, 1'b0);
        push_req(1'b0, 32'h13, 32'h0,        2'd2, 1'b1);
        push_req(1'b0, 32'h12, 32'h0,        2'd1, 1'b0);
        push_req(1'b1, 32'h11, 32'h0000007F, 2'd2, 1'b0);
        push_req(1'b0, 32'h11, 32'h0,        2'd1, 1'b0);
        run(1, 1'b0);
        push_req(1'b0, 32'h10, 32'h0, 2'd0, 1'b0);
        push_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b1);
        push_req(1'b0, 32'h12, 32'h0, 2'd1, 1'b1);
        push_req(1'b1, 32'h10, 32'h80000001, 2'd0, 1'b0);
        push_req(1'b0, 32'h10, 32'h0, 2'd1, 1'b1);
        run(1, 1'b1);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_data_mem_responder
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the memory-stage load/store interface: accepts one request (address, write data, write enable, size, sign) from the memory stage.
- Performs it against an internal word-organised big-endian SRAM after a programmable number of wait states.
- Returns size-aligned, sign- or zero-extended load data.
- Drives a stall back to the pipeline for the whole access; replaces the zero-latency data memory model so slow-memory behaviour can be exercised.

Parameters:
- ADDR_BITS, 12, byte-address bits used; array depth = 2^(ADDR_BITS-2) 32-bit words; upper address bits ignored (wrap).
- WAIT_STATES, 2, extra cycles between accept and array access; 0..15 legal.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  1  request present (memory stage holds it stable while stall=1)
- req_we  in  1  1=store, 0=load
- req_addr  in  [0:31]  byte address, bit 0 MSB
- req_wdata  in  [0:31]  store data, right-justified for byte/half
- req_size  in  [0:1]  00 word, 01 half, 10 byte, 11 illegal
- req_sign  in  1  1=sign-extend load, 0=zero-extend
- stall  out  1  pipeline freeze
- rdata  out  [0:31]  load result
- rvalid  out  1  one-cycle pulse: rdata/err valid
- err  out  1  misaligned/illegal-size flag, qualified by rvalid

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset: state=IDLE, wait counter=0, rdata=0, rvalid=0, err=0, latched request cleared. SRAM contents are not reset.
- FSM IDLE -> WAIT -> ACCESS -> RESP -> IDLE.
  - IDLE: if req_valid, latch all req_* fields. Go to WAIT with counter=WAIT_STATES-1, or to ACCESS directly if WAIT_STATES=0.
  - WAIT: decrement counter; go to ACCESS when counter=0.
  - ACCESS: perform the array read or write with the latched fields; go to RESP.
  - RESP: rvalid=1, rdata/err registered; go to IDLE unconditionally. req_valid in this cycle is ignored: it is the already-served request, and the pipeline advances at this edge.
- stall = (IDLE & req_valid) | WAIT | ACCESS; stall is 0 in RESP. Stall is combinational in IDLE so the pipeline freezes in the request's first cycle.
- Latency: result in cycle WAIT_STATES+2 after first req_valid cycle. Stall asserted for WAIT_STATES+2 cycles. Back-to-back requests: next accept at earliest 1 cycle after RESP.
- Byte lanes are big-endian: addr[30:31]=00 -> bits[0:7], 11 -> bits[24:31].
  - Store byte: write req_wdata[24:31] to the addressed lane only.
  - Store half: addr[30]=0 -> bits[0:15], 1 -> bits[16:31], from req_wdata[16:31].
  - Store word: full word.
  - Load: extract the addressed lane, right-justify, and fill the upper bits with the lane MSB if req_sign, else 0. Word loads ignore req_sign.
- Misalignment (half with addr[31]=1, word with addr[30:31]!=00, or size=11):
  - no array write
  - rdata=0, err=1 in RESP
  - same latency and stall as a legal access
- Stores: rdata=0 in RESP, rvalid still pulses (acknowledge).
- rdata/err hold their RESP values until the next RESP; rvalid=0 outside RESP.
- Reset mid-operation (WAIT/ACCESS): FSM returns to IDLE and stall drops. A pending store not yet in ACCESS is discarded. A write already committed at an ACCESS edge persists.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_WORD/SZ_HALF/SZ_BYTE/SZ_ILLEGAL
  - FSM state encoding
  - the WAIT_STATES legal-range constant
- One sub-module, mem_lane_align: combinational lane-enable/write-data insert and load-extract/extend plus misalign detect. Reused by any future cache.

Test Plan:
- WAIT_STATES=2: store word 0xDEADBEEF @0x10, then load word @0x10, sign=0 -> stall high 4 cycles each; rvalid in 4th cycle; rdata=0xDEADBEEF, err=0.
- Store byte 0x000000A5 @0x21 after word 0x11223344 @0x20; load word @0x20 -> 0x11A53344. Load byte @0x21 sign=1 -> 0xFFFFFFA5; sign=0 -> 0x000000A5.
- Load half @0x22 from 0x1122F344, sign=1 -> 0xFFFFF344. Load half @0x23 -> err=1, rdata=0, memory unchanged.
- Store word @0x12 -> err=1, no write: subsequent load @0x10 still 0xDEADBEEF. Size=11 load -> err=1.
- Reset asserted during WAIT of a store 0xCAFEF00D @0x30 -> stall=0, rvalid=0 immediately. A later load @0x30 returns the prior contents. Separately, WAIT_STATES=0 -> stall 2 cycles, rdata in 2nd cycle.
- Back-to-back load/store stream of 8 requests with req_valid held continuously -> exactly one rvalid per request. No request is accepted during RESP. Address 0x1010 aliases to 0x0010 for ADDR_BITS=12.
